// File: rtl/nios_system_gpio_edge_in_if.sv
// Avalon-MM slave bundle for the GPIO edge input port (register bus plus interrupt).
// Latency: wires only; readdata is registered inside the slave, one cycle after address.
// Backpressure: none; fixed-latency slave, no waitrequest.
// master: drives address/chipselect/write_n/writedata, receives readdata/irq.
// slave : receives address/chipselect/write_n/writedata, drives readdata/irq.
interface nios_system_gpio_edge_in_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/nios_system_gpio_edge_in.sv
// Multi-bit GPIO input: synchroniser, optional glitch filter, rise/fall edge capture, event counter, irq.
// Latency: in_port -> filt SYNC_STAGES (+DEBOUNCE_CYCLES-1) edges, -> capture/irq +1, -> readdata +1.
// Backpressure: none; reads and writes complete every cycle.
// Ports: clk, reset (sync, active-high), in_port[WIDTH] async lines, bus = Avalon-MM slave
//   (address, chipselect, write_n, writedata in; readdata registered, irq combinational out).
module nios_system_gpio_edge_in #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          in_port,
  nios_system_gpio_edge_in_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]     r_sync [SYNC_STAGES];
  logic [WIDTH-1:0]     w_sync;
  logic [WIDTH-1:0]     r_filt;
  logic [WIDTH-1:0]     r_prev;
  logic [WIDTH-1:0]     r_rise_en;
  logic [WIDTH-1:0]     r_fall_en;
  logic [WIDTH-1:0]     r_irq_mask;
  logic [WIDTH-1:0]     r_capture;
  logic [CNT_WIDTH-1:0] r_evt_cnt;
  logic [31:0]          r_readdata;
  logic [31:0]          w_rd_mux;
  logic                 w_wr;
  logic [WIDTH-1:0]     w_clr;
  logic                 w_cnt_clr;
  logic [WIDTH-1:0]     w_ev;
  logic                 w_any_ev;
  logic                 w_unused;

  // Synchroniser chain; last stage is the only one the rest of the design may look at.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES <= 1) begin : g_nofilt
      always_ff @(posedge clk) begin
        if (reset) r_filt <= '0;
        else       r_filt <= w_sync;
      end
    end else begin : g_filt
      localparam int DW = $clog2(DEBOUNCE_CYCLES);
      localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
      logic [DW-1:0] r_dcnt [WIDTH];

      // Per bit: count consecutive disagreeing cycles; accept the new level on the
      // DEBOUNCE_CYCLES-th one. Any agreeing cycle restarts the count.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_filt <= '0;
          for (int b = 0; b < WIDTH; b++) r_dcnt[b] <= '0;
        end else begin
          for (int b = 0; b < WIDTH; b++) begin
            if (w_sync[b] == r_filt[b]) begin
              r_dcnt[b] <= '0;
            end else if (r_dcnt[b] == D_LAST) begin
              r_filt[b] <= w_sync[b];
              r_dcnt[b] <= '0;
            end else begin
              r_dcnt[b] <= r_dcnt[b] + DW'(1);
            end
          end
        end
      end
    end
  endgenerate

  assign w_wr      = bus.chipselect & ~bus.write_n;
  assign w_clr     = (w_wr && (bus.address == 3'd3)) ? bus.writedata[WIDTH-1:0] : '0;
  assign w_cnt_clr = w_wr && (bus.address == 3'd5);
  assign w_ev      = (r_filt & ~r_prev & r_rise_en) | (~r_filt & r_prev & r_fall_en);
  assign w_any_ev  = |w_ev;
  assign w_unused  = &{1'b0, bus.writedata};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev     <= '0;
      r_rise_en  <= '0;
      r_fall_en  <= '0;
      r_irq_mask <= '0;
      r_capture  <= '0;
      r_evt_cnt  <= '0;
      r_readdata <= '0;
    end else begin
      r_prev     <= r_filt;
      r_readdata <= w_rd_mux;
      if (w_wr && (bus.address == 3'd1)) r_rise_en  <= bus.writedata[WIDTH-1:0];
      if (w_wr && (bus.address == 3'd2)) r_irq_mask <= bus.writedata[WIDTH-1:0];
      if (w_wr && (bus.address == 3'd4)) r_fall_en  <= bus.writedata[WIDTH-1:0];
      // OR-ing the new events after the clear keeps an edge that coincides with its own clear.
      r_capture <= (r_capture & ~w_clr) | w_ev;
      if (w_cnt_clr) begin
        r_evt_cnt <= w_any_ev ? CNT_WIDTH'(1) : '0;
      end else if (w_any_ev && (r_evt_cnt != CNT_MAX)) begin
        r_evt_cnt <= r_evt_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // Read mux ignores chipselect so readdata always tracks the addressed register.
  always_comb begin
    w_rd_mux = '0;
    case (bus.address)
      3'd0:    w_rd_mux[WIDTH-1:0]     = r_filt;
      3'd1:    w_rd_mux[WIDTH-1:0]     = r_rise_en;
      3'd2:    w_rd_mux[WIDTH-1:0]     = r_irq_mask;
      3'd3:    w_rd_mux[WIDTH-1:0]     = r_capture;
      3'd4:    w_rd_mux[WIDTH-1:0]     = r_fall_en;
      3'd5:    w_rd_mux[CNT_WIDTH-1:0] = r_evt_cnt;
      default: w_rd_mux                = '0;
    endcase
  end

  assign bus.readdata = r_readdata;
  assign bus.irq      = |(r_capture & r_irq_mask);

endmodule

// File: tb/tb_nios_system_gpio_edge_in.sv
// Bench for the GPIO edge input: two instances driven by identical stimulus,
// u0 = 2 sync stages / no filter / 16-bit counter, u1 = 3 sync stages / 4-cycle filter / 2-bit counter.
// A per-cycle model and hand-computed literal reads are compared against both.
module tb_nios_system_gpio_edge_in;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_port = 8'h00;
  logic [2:0]  addr = 3'd0;
  logic        cs = 1'b0;
  logic        wn = 1'b1;
  logic [31:0] wd = 32'h0;
  logic        chk_en = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  nios_system_gpio_edge_in_if ifc0 ();
  nios_system_gpio_edge_in_if ifc1 ();

  assign ifc0.address = addr;  assign ifc1.address = addr;
  assign ifc0.chipselect = cs; assign ifc1.chipselect = cs;
  assign ifc0.write_n = wn;    assign ifc1.write_n = wn;
  assign ifc0.writedata = wd;  assign ifc1.writedata = wd;

  nios_system_gpio_edge_in #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .CNT_WIDTH(16)) u0 (
    .clk(clk), .reset(reset), .in_port(in_port), .bus(ifc0)
  );
  nios_system_gpio_edge_in #(.WIDTH(8), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(2)) u1 (
    .clk(clk), .reset(reset), .in_port(in_port), .bus(ifc1)
  );

  // ---------------- behavioural model ----------------
  int S    [2] = '{2, 3};
  int N    [2] = '{0, 4};
  int CMAX [2] = '{65535, 3};

  logic [7:0]  hist [$];          // recent in_port samples, newest at back
  logic [7:0]  m_filt [2];
  logic [7:0]  m_prev [2];
  logic [7:0]  m_rise [2];
  logic [7:0]  m_fall [2];
  logic [7:0]  m_mask [2];
  logic [7:0]  m_cap  [2];
  int          m_run  [2][8];     // length of the current disagreement run per bit
  int          m_cnt  [2];
  logic [31:0] m_rd   [2];

  task automatic model_step(input int k, input logic [7:0] sync);
    logic [7:0] ev;
    logic [7:0] nf;
    logic       w;
    w = cs & ~wn;
    case (addr)
      3'd0: m_rd[k] = {24'h0, m_filt[k]};
      3'd1: m_rd[k] = {24'h0, m_rise[k]};
      3'd2: m_rd[k] = {24'h0, m_mask[k]};
      3'd3: m_rd[k] = {24'h0, m_cap[k]};
      3'd4: m_rd[k] = {24'h0, m_fall[k]};
      3'd5: m_rd[k] = 32'(m_cnt[k]);
      default: m_rd[k] = 32'h0;
    endcase
    ev = (m_filt[k] & ~m_prev[k] & m_rise[k]) | (~m_filt[k] & m_prev[k] & m_fall[k]);
    nf = m_filt[k];
    if (N[k] <= 1) begin
      nf = sync;
    end else begin
      for (int b = 0; b < 8; b++) begin
        if (sync[b] != m_filt[k][b]) begin
          m_run[k][b] = m_run[k][b] + 1;
          if (m_run[k][b] == N[k]) begin
            nf[b] = sync[b];
            m_run[k][b] = 0;
          end
        end else begin
          m_run[k][b] = 0;
        end
      end
    end
    m_prev[k] = m_filt[k];
    m_filt[k] = nf;
    if (w && addr == 3'd3) m_cap[k] = (m_cap[k] & ~wd[7:0]) | ev;
    else                   m_cap[k] = m_cap[k] | ev;
    if (w && addr == 3'd5)                  m_cnt[k] = (ev != 8'h0) ? 1 : 0;
    else if (ev != 8'h0 && m_cnt[k] < CMAX[k]) m_cnt[k] = m_cnt[k] + 1;
    if (w && addr == 3'd1) m_rise[k] = wd[7:0];
    if (w && addr == 3'd2) m_mask[k] = wd[7:0];
    if (w && addr == 3'd4) m_fall[k] = wd[7:0];
  endtask

  always @(posedge clk) begin
    if (reset) begin
      hist.delete();
      for (int i = 0; i < 3; i++) hist.push_back(8'h00);
      for (int k = 0; k < 2; k++) begin
        m_filt[k] = 0; m_prev[k] = 0; m_rise[k] = 0; m_fall[k] = 0;
        m_mask[k] = 0; m_cap[k] = 0; m_cnt[k] = 0; m_rd[k] = 0;
        for (int b = 0; b < 8; b++) m_run[k][b] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) model_step(k, hist[hist.size() - S[k]]);
      hist.push_back(in_port);
      void'(hist.pop_front());
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("model_rd_u0",  ifc0.readdata, m_rd[0]);
      chk("model_irq_u0", {31'h0, ifc0.irq}, {31'h0, |(m_cap[0] & m_mask[0])});
      chk("model_rd_u1",  ifc1.readdata, m_rd[1]);
      chk("model_irq_u1", {31'h0, ifc1.irq}, {31'h0, |(m_cap[1] & m_mask[1])});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wd = d; cs = 1'b1; wn = 1'b0;
    @(negedge clk);
    cs = 1'b0; wn = 1'b1;
  endtask

  task automatic rd(input int k, input logic [2:0] a, input logic [31:0] exp, input string nm);
    @(negedge clk);
    addr = a; cs = 1'b0; wn = 1'b1;
    @(posedge clk);
    #1;
    chk(nm, (k == 0) ? ifc0.readdata : ifc1.readdata, exp);
  endtask

  task automatic rd_both(input logic [2:0] a, input logic [31:0] e0, input logic [31:0] e1, input string nm);
    rd(0, a, e0, {nm, "_u0"});
    rd(1, a, e1, {nm, "_u1"});
  endtask

  // Holds address 0 and applies a pulse of len cycles on bit2; counts cycles DATA bit2 reads 1.
  task automatic pulse_bit2(input int len, output int c0, output int c1);
    c0 = 0; c1 = 0;
    @(negedge clk);
    addr = 3'd0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      in_port = (i < len) ? 8'h84 : 8'h80;
      @(posedge clk);
      #1;
      if (ifc0.readdata[2]) c0++;
      if (ifc1.readdata[2]) c1++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0, c1;
    // Reset state
    cyc(3);
    @(posedge clk); #1;
    chk("reset_rd_u0",  ifc0.readdata, 32'h0);
    chk("reset_irq_u0", {31'h0, ifc0.irq}, 32'h0);
    chk("reset_rd_u1",  ifc1.readdata, 32'h0);
    chk("reset_irq_u1", {31'h0, ifc1.irq}, 32'h0);
    @(negedge clk);
    chk_en = 1'b1;
    reset = 1'b0;

    // T1: single rising edge on bit0, irq exactly three edges after sampling on u0
    wr(3'd1, 32'hFF);
    wr(3'd2, 32'h01);
    @(negedge clk);
    in_port = 8'h01;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("t1_irq_lat_e%0d", i), {31'h0, ifc0.irq}, (i == 3) ? 32'h1 : 32'h0);
    end
    cyc(12);
    rd_both(3'd3, 32'h01, 32'h01, "t1_capture");
    rd_both(3'd5, 32'h1, 32'h1, "t1_evtcnt");
    rd_both(3'd0, 32'h01, 32'h01, "t1_data");

    // T2: falling enable only on bit7
    wr(3'd1, 32'h00);
    wr(3'd4, 32'h80);
    wr(3'd3, 32'hFF);
    wr(3'd5, 32'h0);
    @(negedge clk); in_port = 8'h80;
    cyc(12);
    rd_both(3'd3, 32'h00, 32'h00, "t2_no_capture");
    @(negedge clk); in_port = 8'h00;
    cyc(12);
    rd_both(3'd3, 32'h80, 32'h80, "t2_fall_capture");
    rd_both(3'd5, 32'h1, 32'h1, "t2_fall_cnt");
    @(negedge clk); in_port = 8'h80;
    cyc(12);
    rd_both(3'd3, 32'h80, 32'h80, "t2_rise_ignored");
    rd_both(3'd5, 32'h1, 32'h1, "t2_cnt_same");

    // T3: glitch filter, 3-cycle pulse is dropped by u1, 4-cycle pulse passes
    wr(3'd1, 32'h04);
    wr(3'd4, 32'h00);
    wr(3'd3, 32'hFF);
    wr(3'd5, 32'h0);
    pulse_bit2(3, c0, c1);
    chk("t3_p3_width_u0", 32'(c0), 32'd3);
    chk("t3_p3_width_u1", 32'(c1), 32'd0);
    rd_both(3'd3, 32'h04, 32'h00, "t3_p3_capture");
    rd_both(3'd5, 32'h1, 32'h0, "t3_p3_cnt");
    rd_both(3'd0, 32'h80, 32'h80, "t3_p3_data");
    wr(3'd3, 32'hFF);
    wr(3'd5, 32'h0);
    pulse_bit2(4, c0, c1);
    chk("t3_p4_width_u0", 32'(c0), 32'd4);
    chk("t3_p4_width_u1", 32'(c1), 32'd4);
    rd_both(3'd3, 32'h04, 32'h04, "t3_p4_capture");
    rd_both(3'd5, 32'h1, 32'h1, "t3_p4_cnt");

    // T4: clear of bit0 in the same cycle as a new bit0 edge on u0
    wr(3'd3, 32'hFF);
    wr(3'd5, 32'h0);
    wr(3'd1, 32'h03);
    wr(3'd2, 32'h03);
    @(negedge clk); in_port = 8'h83;
    cyc(12);
    rd_both(3'd3, 32'h03, 32'h03, "t4_setup");
    @(negedge clk); in_port = 8'h82;
    cyc(12);
    @(negedge clk); in_port = 8'h83;
    cyc(2);
    wr(3'd3, 32'h01);
    cyc(12);
    rd_both(3'd3, 32'h03, 32'h03, "t4_set_beats_clr");
    chk("t4_irq_u0", {31'h0, ifc0.irq}, 32'h1);
    wr(3'd3, 32'h03);
    rd_both(3'd3, 32'h00, 32'h00, "t4_cleared");
    chk("t4_irq_low_u0", {31'h0, ifc0.irq}, 32'h0);
    chk("t4_irq_low_u1", {31'h0, ifc1.irq}, 32'h0);

    // T5: counter saturation on u1 and clear coinciding with an event
    wr(3'd1, 32'h01);
    wr(3'd5, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); in_port = 8'h82;
      cyc(12);
      @(negedge clk); in_port = 8'h83;
      cyc(12);
    end
    rd_both(3'd5, 32'd5, 32'd3, "t5_saturate");
    @(negedge clk); in_port = 8'h82;
    cyc(12);
    @(negedge clk); in_port = 8'h83;
    cyc(6);
    wr(3'd5, 32'h0);
    cyc(12);
    rd_both(3'd5, 32'd0, 32'd1, "t5_clr_with_event");

    // T6: reset mid-pulse with flags pending
    @(negedge clk); addr = 3'd3; in_port = 8'h82;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("t6_rd_u0",  ifc0.readdata, 32'h0);
    chk("t6_irq_u0", {31'h0, ifc0.irq}, 32'h0);
    chk("t6_rd_u1",  ifc1.readdata, 32'h0);
    chk("t6_irq_u1", {31'h0, ifc1.irq}, 32'h0);
    @(negedge clk); reset = 1'b0; in_port = 8'h83;
    cyc(14);
    rd_both(3'd3, 32'h00, 32'h00, "t6_no_capture");
    rd_both(3'd5, 32'h0, 32'h0, "t6_cnt");
    rd_both(3'd0, 32'h83, 32'h83, "t6_data");
    chk("t6_irq_after_u1", {31'h0, ifc1.irq}, 32'h0);

    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
